// File: rtl/rx_pkt_drain_if.sv
// PHY RX buffer pop side plus Data Link Layer valid/ready side of the receive drain stage.
// slave = drain stage, master = environment (buffer + DLL).
interface rx_pkt_drain_if #(
   parameter int DATA_WIDTH       = 256,
   parameter int PACKET_LENGTH    = 11,
   parameter int SYMBOL_PTR_WIDTH = 5,
   parameter int CNT_WIDTH        = 16
);
   localparam int NB = DATA_WIDTH / 8;

   logic                        i_Empty;
   logic                        o_RD_EN;
   logic [0:DATA_WIDTH-1]       i_Data;
   logic                        i_SOP;
   logic                        i_End_Valid;
   logic                        i_Type;
   logic [PACKET_LENGTH-1:0]    i_Length;
   logic [SYMBOL_PTR_WIDTH-1:0] i_Last_Byte;
   logic                        i_RX_Error;
   logic                        o_Valid;
   logic                        i_Ready;
   logic [0:DATA_WIDTH-1]       o_Data;
   logic                        o_SOP;
   logic                        o_EOP;
   logic                        o_Type;
   logic [0:NB-1]               o_Byte_En;
   logic                        o_Drop;
   logic                        o_Abort;
   logic [CNT_WIDTH-1:0]        o_Pkt_Count;
   logic [CNT_WIDTH-1:0]        o_Err_Count;

   modport slave (
      input  i_Empty, i_Data, i_SOP, i_End_Valid, i_Type, i_Length, i_Last_Byte, i_RX_Error, i_Ready,
      output o_RD_EN, o_Valid, o_Data, o_SOP, o_EOP, o_Type, o_Byte_En, o_Drop, o_Abort,
             o_Pkt_Count, o_Err_Count
   );

   modport master (
      output i_Empty, i_Data, i_SOP, i_End_Valid, i_Type, i_Length, i_Last_Byte, i_RX_Error, i_Ready,
      input  o_RD_EN, o_Valid, o_Data, o_SOP, o_EOP, o_Type, o_Byte_En, o_Drop, o_Abort,
             o_Pkt_Count, o_Err_Count
   );
endinterface

// File: rtl/rx_pkt_drain.sv
// RX drain: pops PHY buffer beats, checks framing/length, presents them with byte enables, drop/abort flags and stats.
// Pop to o_Valid is 2 cycles; a 2-entry skid holds beats under backpressure and pops stop when skid + in-flight reach 2.
module rx_pkt_drain #(
   parameter int DATA_WIDTH       = 256,
   parameter int PACKET_LENGTH    = 11,
   parameter int SYMBOL_PTR_WIDTH = 5,
   parameter int CNT_WIDTH        = 16
) (
   input logic          CLK,
   input logic          RST_L,
   rx_pkt_drain_if.slave bus
);
   localparam int NB = DATA_WIDTH / 8;

   typedef struct packed {
      logic [0:DATA_WIDTH-1] data;
      logic                  sop;
      logic                  eop;
      logic                  typ;
      logic [0:NB-1]         be;
      logic                  drop;
      logic                  abort;
   } beat_t;

   typedef enum logic {IDLE, IN_PKT} state_t;

   state_t                   state_q, state_d;
   logic [PACKET_LENGTH-1:0] len_q, len_d, cnt_q, cnt_d;
   logic                     type_q, type_d, err_q, err_d;
   logic                     inflight_q;
   beat_t                    mem_q [2];
   logic                     wr_ptr_q, rd_ptr_q;
   logic [1:0]               occ_q;
   logic [CNT_WIDTH-1:0]     pkt_cnt_q, err_cnt_q;

   logic                     wr_en, err_ev, deq, rd_en, good_eop;
   logic [1:0]               occ_eff, slots_used;
   logic [PACKET_LENGTH-1:0] exp_beats, len_m1;
   beat_t                    beat_w, head;

   // A beat leaving this cycle frees its slot for a pop issued this cycle, giving full throughput.
   assign deq        = bus.o_Valid && bus.i_Ready;
   assign occ_eff    = occ_q - {1'b0, deq};
   assign slots_used = occ_eff + {1'b0, inflight_q};
   assign rd_en      = !bus.i_Empty && (slots_used < 2'd2);
   assign bus.o_RD_EN = rd_en;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      type_d    = type_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      wr_en     = 1'b0;
      err_ev    = 1'b0;
      beat_w    = '0;
      exp_beats = '0;
      len_m1    = '0;
      if (state_q == IN_PKT && bus.i_RX_Error) err_d = 1'b1;
      if (inflight_q) begin
         if (bus.i_SOP) begin
            len_d        = bus.i_Length;
            type_d       = bus.i_Type;
            cnt_d        = PACKET_LENGTH'(1);
            err_d        = bus.i_RX_Error;
            state_d      = bus.i_End_Valid ? IDLE : IN_PKT;
            beat_w.abort = (state_q == IN_PKT);
            wr_en        = 1'b1;
         end else if (state_q == IN_PKT) begin
            cnt_d = cnt_q + PACKET_LENGTH'(1);
            err_d = err_q | bus.i_RX_Error;
            wr_en = 1'b1;
            if (bus.i_End_Valid) state_d = IDLE;
         end else begin
            err_ev = 1'b1;
         end
         if (wr_en) begin
            exp_beats   = (len_d + PACKET_LENGTH'(NB - 1)) >> SYMBOL_PTR_WIDTH;
            len_m1      = len_d - PACKET_LENGTH'(1);
            beat_w.data = bus.i_Data;
            beat_w.sop  = bus.i_SOP;
            beat_w.eop  = bus.i_End_Valid;
            beat_w.typ  = type_d;
            for (int k = 0; k < NB; k++)
               beat_w.be[k] = !bus.i_End_Valid || (k <= int'(bus.i_Last_Byte));
            beat_w.drop = bus.i_End_Valid &&
                          ((cnt_d != exp_beats) ||
                           (bus.i_Last_Byte != len_m1[SYMBOL_PTR_WIDTH-1:0]) ||
                           (len_d == '0) || err_d);
            err_ev = beat_w.abort || beat_w.drop;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         state_q <= IDLE;
         len_q   <= '0;
         type_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         type_q  <= type_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign head     = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
   assign good_eop = deq && head.eop && !head.drop;

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         inflight_q <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         occ_q      <= 2'd0;
         pkt_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         inflight_q <= rd_en;
         if (wr_en) begin
            mem_q[wr_ptr_q] <= beat_w;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (deq) rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_q + {1'b0, wr_en} - {1'b0, deq};
         if (good_eop && pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
         if (err_ev && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign bus.o_Valid     = (occ_q != 2'd0);
   assign bus.o_Data      = head.data;
   assign bus.o_SOP       = head.sop;
   assign bus.o_EOP       = head.eop;
   assign bus.o_Type      = head.typ;
   assign bus.o_Byte_En   = head.be;
   assign bus.o_Drop      = head.drop;
   assign bus.o_Abort     = head.abort;
   assign bus.o_Pkt_Count = pkt_cnt_q;
   assign bus.o_Err_Count = err_cnt_q;
endmodule

// File: doc/rx_pkt_drain.md
# rx_pkt_drain

Receive-side drain stage directly downstream of the PHY receive packet buffer. It pops framed beats whenever the buffer is non-empty and the stage has room. It checks packet framing and length against the carried header fields, and presents beats to the Data Link Layer over a valid/ready interface with per-byte enables and a drop flag. It also keeps saturating packet and error counters for link status.

## Interface
Parameters:
- DATA_WIDTH, 256, beat width in bits (byte count NB = DATA_WIDTH/8 = 32)
- PACKET_LENGTH, 11, width of packet length field (bytes)
- SYMBOL_PTR_WIDTH, 5, width of last-byte index (log2 NB)
- CNT_WIDTH, 16, statistics counter width

Ports:
- CLK  in  1  single clock for the block
- RST_L  in  1  asynchronous, active-low reset
- i_Empty  in  1  PHY RX buffer empty
- o_RD_EN  out  1  pop request to PHY RX buffer; buffer data valid the cycle after
- i_Data  in  [0:DATA_WIDTH-1]  beat data; byte k = bits [8k:8k+7]
- i_SOP, i_End_Valid, i_Type  in  1 each  start of packet, last beat, 0=DLLP 1=TLP
- i_Length  in  PACKET_LENGTH  packet length in bytes, meaningful on SOP beat
- i_Last_Byte  in  SYMBOL_PTR_WIDTH  index of last valid byte, meaningful on end beat
- i_RX_Error  in  1  PHY receive error (level)
- o_Valid  out  1  output beat valid
- i_Ready  in  1  Data Link Layer accepts beat
- o_Data  out  [0:DATA_WIDTH-1]  beat data
- o_SOP, o_EOP, o_Type  out  1 each  framing
- o_Byte_En  out  [0:NB-1]  valid bytes; bit k = byte k
- o_Drop  out  1  on EOP beat: discard whole packet
- o_Abort  out  1  on SOP beat: previous packet never terminated, discard its partial beats
- o_Pkt_Count, o_Err_Count  out  CNT_WIDTH  good packets / error events, saturating

## Operation
- Output storage is a 2-entry FIFO (skid). o_RD_EN = !i_Empty && (occupancy + reads_in_flight < 2). reads_in_flight is 1 the cycle after a pop, else 0.
- Returned beat (cycle after pop) is classified and written to the skid FIFO.
- Framing FSM, states IDLE, IN_PKT:
  - IDLE + SOP: latch Length and Type, beat count = 1, clear error flag. If End_Valid also set, the beat is a single-beat packet and the FSM stays in IDLE. Otherwise go to IN_PKT.
  - IDLE + non-SOP: orphan beat. Discarded (not written), Err_Count += 1.
  - IN_PKT + non-SOP: beat count += 1. On End_Valid go to IDLE.
  - IN_PKT + SOP: write the beat with o_SOP=1 and o_Abort=1, Err_Count += 1. Restart as in IDLE + SOP.
- Length check on end beat (11-bit arithmetic, Length 0 illegal):
  - expected beats = (Length + NB-1) >> 5
  - expected Last_Byte = (Length - 1) & (NB-1)
  - Any mismatch, Length==0, or any i_RX_Error seen during the packet (SOP through end beat inclusive) sets o_Drop=1 on the EOP beat and Err_Count += 1 (once per packet).
- o_Byte_En: all ones on non-EOP beats. On EOP beats, bits 0..Last_Byte are 1 and the rest 0.
- o_Type is the latched SOP type on every beat of the packet.
- o_Pkt_Count += 1 on each handshake (o_Valid && i_Ready) of an EOP beat with o_Drop=0.
- Both counters saturate at all-ones.
- Simultaneous error events in one cycle (e.g. abort plus RX error) increment Err_Count by 1 only.

## Timing
- Reset: o_RD_EN, o_Valid, o_SOP, o_EOP, o_Type, o_Drop, o_Abort = 0; o_Data = 0; o_Byte_En = 0; counters = 0; FSM = IDLE; skid FIFO empty.
- Latency: pop in cycle t, buffer data at t+1, o_Valid at t+2.
- Throughput: 1 beat/cycle sustained with i_Ready held high and buffer non-empty.
- Handshake: o_Valid, once high, holds with all output fields stable until i_Ready is sampled high. i_Ready may toggle freely.
- Backpressure: with i_Ready low, at most 2 beats are buffered. No beat is lost or duplicated. o_RD_EN drops in the same cycle occupancy + in-flight reaches 2.
- i_Empty rising while a read is in flight does not cancel that read.
- Asynchronous reset mid-packet discards buffered beats and the in-flight read; the FSM returns to IDLE.

## Test plan
- Single TLP, Length=100, 4 beats, Last_Byte=3, i_Ready=1:
  - 4 beats out, o_Valid first at pop+2
  - Byte_En on EOP beat = bits 0..3 set
  - o_Drop=0, Pkt_Count=1
- Length=64 but 3 beats delivered: EOP beat has o_Drop=1, Err_Count=1, Pkt_Count=0.
- Back-to-back 1-beat DLLPs (SOP+End_Valid), Length=6, Last_Byte=5:
  - 10 packets in 10 consecutive cycles
  - Pkt_Count=10
- i_Ready low for 20 cycles during a 6-beat packet:
  - o_RD_EN low once 2 beats are held
  - all 6 beats delivered in order after release, data matches
- SOP arrives mid-packet: the new SOP beat carries o_Abort=1, Err_Count=1, and the new packet completes normally.
- i_RX_Error pulsed one cycle mid-packet: EOP o_Drop=1; the next clean packet has o_Drop=0. Then assert reset mid-packet: all outputs 0 and the next SOP is accepted.
